// File: rtl/o_buft_bus_driver.sv
// Tristate output bus driver: one O_BUFT per bit behind an ON/DRIVE/HOLD/GAP sequencer.
// The sequencer keeps the pad bus free of overlapping drivers and caps the burst length.
module o_buft_bus_driver #(
   parameter int unsigned       WIDTH     = 8,
   parameter int unsigned       ON_DLY    = 2,
   parameter int unsigned       HOLD_CYC  = 1,
   parameter int unsigned       GAP_CYC   = 2,
   parameter int unsigned       MAX_BURST = 16,
   parameter logic [WIDTH-1:0]  IDLE_VAL  = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              drv_req,
   input  logic              drv_valid,
   input  logic [WIDTH-1:0]  drv_data,
   output logic              drv_ready,
   output logic [WIDTH-1:0]  bus_o,
   output logic              oe_o,
   output logic              busy_o,
   output logic [15:0]       burst_cnt_o,
   output logic [2:0]        state_o
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ON    = 3'd1,
      ST_DRIVE = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   localparam int unsigned MAX_DLY = (ON_DLY > HOLD_CYC) ?
                                     ((ON_DLY > GAP_CYC) ? ON_DLY : GAP_CYC) :
                                     ((HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC);
   localparam int unsigned CNT_W   = $clog2(MAX_DLY + 1);

   localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_DLY - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   dly_q, dly_d;
   logic [WIDTH-1:0]   i_q;
   logic               t_q, t_d;
   logic [15:0]        burst_cnt_q;
   logic               limit_hit;
   logic               accept;
   logic               start_burst;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      dly_d       = dly_q;
      limit_hit   = (MAX_BURST != 0) && ({16'd0, burst_cnt_q} >= MAX_BURST);
      drv_ready   = (state_q == ST_DRIVE) && !limit_hit;
      accept      = drv_ready && drv_valid;
      start_burst = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (drv_req) begin
               state_d     = ST_ON;
               start_burst = 1'b1;
            end
         end
         // drv_req is judged at the edge that ends ON; a drop earlier in ON is not latched.
         ST_ON: begin
            if (dly_q == ON_LAST) state_d = drv_req ? ST_DRIVE : ST_HOLD;
            else                  dly_d   = dly_q + CNT_W'(1);
         end
         ST_DRIVE: begin
            if (limit_hit || !drv_req) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (dly_q == HOLD_LAST) state_d = ST_GAP;
            else                    dly_d   = dly_q + CNT_W'(1);
         end
         ST_GAP: begin
            if (dly_q == GAP_LAST) state_d = ST_IDLE;
            else                   dly_d   = dly_q + CNT_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d != state_q) dly_d = '0;
      t_d = (state_d == ST_ON) || (state_d == ST_DRIVE) || (state_d == ST_HOLD);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         dly_q       <= '0;
         t_q         <= 1'b0;
         i_q         <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
         t_q     <= t_d;
         if (start_burst) begin
            i_q         <= IDLE_VAL;
            burst_cnt_q <= '0;
         end else if (accept) begin
            i_q <= drv_data;
            if (burst_cnt_q != 16'hFFFF) burst_cnt_q <= burst_cnt_q + 16'd1;
         end
      end
   end

   // Per-bit O_BUFT: I and T come straight from flops, O goes to the pad.
   for (genvar b = 0; b < WIDTH; b++) begin : g_o_buft
      assign bus_o[b] = t_q ? i_q[b] : 1'bz;
   end

   assign oe_o        = t_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign burst_cnt_o = burst_cnt_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_o_buft_bus_driver.sv
// Bench for o_buft_bus_driver: phase/countdown reference model, directed scenarios, random traffic.
module tb_o_buft_bus_driver;

   localparam int          W         = 8;
   localparam int          ON_DLY    = 2;
   localparam int          HOLD_CYC  = 1;
   localparam int          GAP_CYC   = 2;
   localparam int          MAX_BURST = 4;
   localparam logic [7:0]  IDLE_VAL  = 8'h5A;

   localparam int P_IDLE = 0, P_ON = 1, P_DRIVE = 2, P_HOLD = 3, P_GAP = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          drv_req = 1'b0;
   logic          drv_valid = 1'b0;
   logic [W-1:0]  drv_data = '0;
   logic          drv_ready;
   wire  [W-1:0]  bus_o;
   logic          oe_o;
   logic          busy_o;
   logic [15:0]   burst_cnt_o;
   logic [2:0]    state_o;

   o_buft_bus_driver #(
      .WIDTH(W), .ON_DLY(ON_DLY), .HOLD_CYC(HOLD_CYC), .GAP_CYC(GAP_CYC),
      .MAX_BURST(MAX_BURST), .IDLE_VAL(IDLE_VAL)
   ) dut (
      .clk(clk), .rst(rst), .drv_req(drv_req), .drv_valid(drv_valid), .drv_data(drv_data),
      .drv_ready(drv_ready), .bus_o(bus_o), .oe_o(oe_o), .busy_o(busy_o),
      .burst_cnt_o(burst_cnt_o), .state_o(state_o)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad = 0;
   bit   checking = 1'b0;

   // Reference model: current phase, cycles left in it, word on the pads, words this burst.
   int          m_phase;
   int          m_left;
   int          m_cnt;
   logic [7:0]  m_bus;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_room();
      return (MAX_BURST == 0) || (m_cnt < MAX_BURST);
   endfunction

   function automatic bit m_driving();
      return (m_phase == P_ON) || (m_phase == P_DRIVE) || (m_phase == P_HOLD);
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE;
      m_left  = 0;
      m_cnt   = 0;
      m_bus   = '0;
   endtask

   task automatic model_step(input bit req, input bit valid, input logic [7:0] data);
      case (m_phase)
         P_IDLE: if (req) begin
            m_phase = P_ON; m_left = ON_DLY; m_bus = IDLE_VAL; m_cnt = 0;
         end
         P_ON: begin
            m_left--;
            if (m_left == 0) begin
               m_phase = req ? P_DRIVE : P_HOLD;
               m_left  = req ? 0 : HOLD_CYC;
            end
         end
         P_DRIVE: begin
            bit room = m_room();
            if (room && valid) begin
               m_bus = data;
               if (m_cnt < 65535) m_cnt++;
            end
            if (!room || !req) begin
               m_phase = P_HOLD; m_left = HOLD_CYC;
            end
         end
         P_HOLD: begin
            m_left--;
            if (m_left == 0) begin
               m_phase = P_GAP; m_left = GAP_CYC;
            end
         end
         default: begin
            m_left--;
            if (m_left == 0) m_phase = P_IDLE;
         end
      endcase
   endtask

   always @(negedge clk) begin
      if (checking) begin
         check("state", 32'(state_o), 32'(m_phase));
         check("oe", 32'(oe_o), 32'(m_driving()));
         check("busy", 32'(busy_o), 32'(m_phase != P_IDLE));
         check("ready", 32'(drv_ready), 32'((m_phase == P_DRIVE) && m_room()));
         check("burst_cnt", 32'(burst_cnt_o), 32'(m_cnt));
         if (m_driving()) check("bus", 32'(bus_o), 32'(m_bus));
      end
   end

   // One clock: inputs applied after a falling edge, model advanced on the rising edge.
   task automatic cycle(input bit req, input bit valid, input logic [7:0] data);
      drv_req   = req;
      drv_valid = valid;
      drv_data  = data;
      @(posedge clk);
      model_step(req, valid, data);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] words [4];
      bit         rq;

      model_reset();
      repeat (2) @(negedge clk);
      checking = 1'b1;
      check("rst_oe", 32'(oe_o), 32'd0);
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_cnt", 32'(burst_cnt_o), 32'd0);
      rst = 1'b1;
      cycle(0, 0, 8'h00);
      cycle(0, 0, 8'h00);
      check("idle_state", 32'(state_o), 32'd0);
      check("idle_oe", 32'(oe_o), 32'd0);

      // Basic burst: ON for two cycles, words A5 and 3C, HOLD one, GAP two.
      cycle(1, 0, 8'h00);
      check("on_state", 32'(state_o), 32'd1);
      check("on_bus", 32'(bus_o), 32'h5A);
      cycle(1, 0, 8'h00);
      cycle(1, 1, 8'hFF);
      check("drive_state", 32'(state_o), 32'd2);
      check("drive_no_take", 32'(burst_cnt_o), 32'd0);
      cycle(1, 1, 8'hA5);
      check("word1", 32'(bus_o), 32'hA5);
      cycle(0, 1, 8'h3C);
      check("hold_state", 32'(state_o), 32'd3);
      check("hold_bus", 32'(bus_o), 32'h3C);
      cycle(0, 0, 8'h00);
      check("gap_state", 32'(state_o), 32'd4);
      check("gap_oe", 32'(oe_o), 32'd0);
      cycle(0, 0, 8'h00);
      cycle(0, 0, 8'h00);
      check("back_idle", 32'(state_o), 32'd0);
      check("basic_cnt", 32'(burst_cnt_o), 32'd2);

      // Forced termination at four words with request and valid held high.
      for (int k = 0; k < 4; k++) words[k] = 8'($urandom);
      repeat (3) cycle(1, 1, 8'h11);
      for (int k = 0; k < 4; k++) cycle(1, 1, words[k]);
      check("max_cnt", 32'(burst_cnt_o), 32'd4);
      check("max_ready", 32'(drv_ready), 32'd0);
      check("max_bus", 32'(bus_o), 32'(words[3]));
      cycle(1, 1, 8'h22);
      check("max_hold", 32'(state_o), 32'd3);
      check("max_hold_cnt", 32'(burst_cnt_o), 32'd4);
      cycle(1, 1, 8'h22);
      cycle(1, 1, 8'h22);
      cycle(1, 1, 8'h22);
      check("max_idle", 32'(state_o), 32'd0);
      cycle(1, 1, 8'h22);
      check("max_reon", 32'(state_o), 32'd1);

      // Request dropped in ON: ON still completes, then HOLD with no words.
      cycle(0, 1, 8'h33);
      check("drop_still_on", 32'(state_o), 32'd1);
      cycle(0, 1, 8'h33);
      check("drop_hold", 32'(state_o), 32'd3);
      check("drop_cnt", 32'(burst_cnt_o), 32'd0);
      check("drop_bus", 32'(bus_o), 32'h5A);
      cycle(0, 0, 8'h00);
      cycle(1, 0, 8'h00);
      cycle(0, 0, 8'h00);
      cycle(0, 0, 8'h00);
      check("gap_req_ignored", 32'(state_o), 32'd0);

      // Back-pressure: valid toggles, only accepted edges move the pads.
      repeat (3) cycle(1, 0, 8'h00);
      for (int k = 0; k < 6; k++) cycle(1, k[0], 8'(8'h40 + k));
      repeat (6) cycle(0, 0, 8'h00);

      // Asynchronous reset mid-DRIVE releases the bus before the next edge.
      repeat (3) cycle(1, 0, 8'h00);
      cycle(1, 1, 8'h77);
      drv_req = 1'b0; drv_valid = 1'b0;
      #2 rst = 1'b0;
      model_reset();
      #1;
      check("arst_oe", 32'(oe_o), 32'd0);
      check("arst_state", 32'(state_o), 32'd0);
      check("arst_ready", 32'(drv_ready), 32'd0);
      check("arst_cnt", 32'(burst_cnt_o), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Random traffic with sticky requests and occasional asynchronous resets.
      rq = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 399) == 0) begin
            drv_req = 1'b0; drv_valid = 1'b0;
            #2 rst = 1'b0;
            model_reset();
            @(negedge clk);
            rst = 1'b1;
         end else begin
            if ($urandom_range(0, 7) == 0) rq = ~rq;
            cycle(rq, 1'($urandom_range(0, 1)), 8'($urandom));
         end
      end

      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
